// File: rtl/tlp_fifo_pkg.sv
// Shared TLP defines: default FIFO geometry and reset thresholds, used by the
// flow-control FSM, the TLP muxes and the FIFO itself.
package tlp_fifo_pkg;

   localparam int TLP_DATA_WIDTH = 6;
   localparam int TLP_ADDR_WIDTH = 2;

   // Almost-empty threshold loaded by reset.
   localparam int TLP_AE_RESET   = 1;

   // Almost-full threshold loaded by reset: one below depth.
   function automatic int tlp_af_reset(input int addr_width);
      return (1 << addr_width) - 1;
   endfunction

endpackage

// File: rtl/tlp_fifo_if.sv
// FIFO bus between the flow-control FSM (master) and a TLP FIFO (slave):
// control strobes, thresholds, write/read handshakes and status flags.
interface tlp_fifo_if
   import tlp_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = TLP_DATA_WIDTH,
   parameter int ADDR_WIDTH = TLP_ADDR_WIDTH
);
   logic                  init;
   logic [ADDR_WIDTH:0]   umbral_af;
   logic [ADDR_WIDTH:0]   umbral_ae;
   logic                  push;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pop;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  error;
   logic [ADDR_WIDTH:0]   count;

   modport master (
      output init, umbral_af, umbral_ae, push, data_in, pop,
      input  data_out, valid_out, full, empty, almost_full, almost_empty,
             error, count
   );

   modport slave (
      input  init, umbral_af, umbral_ae, push, data_in, pop,
      output data_out, valid_out, full, empty, almost_full, almost_empty,
             error, count
   );
endinterface

// File: rtl/tlp_fifo_mem.sv
// Storage array for tlp_fifo: DEPTH x DATA_WIDTH registers with a synchronous
// write port and an address-indexed read port.
module fifo_mem
   import tlp_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = TLP_DATA_WIDTH,
   parameter int ADDR_WIDTH = TLP_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset; occupancy lives in the pointers and count,
   // so stale words are never observable and a reset tree here would be waste.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tlp_fifo.sv
// TLP FIFO: pointers, occupancy, programmable almost-full/empty flags and a
// sticky overflow/underflow flag around a fifo_mem array; 1-cycle pop latency.
module tlp_fifo
   import tlp_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = TLP_DATA_WIDTH,
   parameter int ADDR_WIDTH = TLP_ADDR_WIDTH
) (
   input logic       clk,
   input logic       reset,
   tlp_fifo_if.slave bus
);
   localparam int                DEPTH  = 1 << ADDR_WIDTH;
   localparam int                CNT_W  = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]  AF_RST = CNT_W'(tlp_af_reset(ADDR_WIDTH));
   localparam logic [CNT_W-1:0]  AE_RST = CNT_W'(TLP_AE_RESET);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      r_af;
   logic [CNT_W-1:0]      r_ae;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_valid_out;
   logic                  r_error;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic                  w_reject;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   // Acceptance is judged on the pre-edge count, so push+pop on a full FIFO
   // drains one word and push+pop on an empty FIFO stores one word.
   assign w_push_ok = bus.push & ~w_full  & ~bus.init;
   assign w_pop_ok  = bus.pop  & ~w_empty & ~bus.init;
   assign w_reject  = ~bus.init & ((bus.push & w_full) | (bus.pop & w_empty));

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push_ok),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // NOTE: all state here updates with non-blocking assignments so every
   // register sees the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_af        <= AF_RST;
         r_ae        <= AE_RST;
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
         r_error     <= 1'b0;
      end else if (bus.init) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_af        <= bus.umbral_af;
         r_ae        <= bus.umbral_ae;
         r_valid_out <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_pop_ok) begin
            r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
            r_data_out <= w_rdata;
         end
         r_valid_out <= w_pop_ok;
         r_count     <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
         if (w_reject) r_error <= 1'b1;
      end
   end

   assign bus.data_out     = r_data_out;
   assign bus.valid_out    = r_valid_out;
   assign bus.count        = r_count;
   assign bus.error        = r_error;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = (r_count >= r_af);
   assign bus.almost_empty = (r_count <= r_ae);

endmodule

// File: tb/tb_tlp_fifo.sv
// Directed self-checking bench for tlp_fifo: fill/drain, overflow, underflow,
// init thresholds, wrap-around and asynchronous reset.
module tb_tlp_fifo;
   import tlp_fifo_pkg::*;

   localparam int DW = 6;
   localparam int AW = 2;

   logic clk;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;

   tlp_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   tlp_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
      bus.push    = p;
      bus.data_in = d;
      bus.pop     = q;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   task automatic do_init(input logic [AW:0] af, input logic [AW:0] ae);
      bus.init      = 1'b1;
      bus.umbral_af = af;
      bus.umbral_ae = ae;
      @(posedge clk);
      #1;
      bus.init = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, 32'(bus.count), 0);
      check({tag, "_empty"}, 32'(bus.empty), 1);
      check({tag, "_full"},  32'(bus.full),  0);
      check({tag, "_ae"},    32'(bus.almost_empty), 1);
      check({tag, "_af"},    32'(bus.almost_full),  0);
      check({tag, "_valid"}, 32'(bus.valid_out), 0);
      check({tag, "_dout"},  32'(bus.data_out), 0);
      check({tag, "_error"}, 32'(bus.error), 0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.init      = 1'b0;
      bus.umbral_af = '0;
      bus.umbral_ae = '0;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.data_in   = '0;
      #2;
      check_reset_state("rst");
      #1 reset = 1'b0;

      // Fill to full, then drain in order.
      step(1, 6'h01, 0);
      check("s1_cnt1", 32'(bus.count), 1);
      check("s1_ae1",  32'(bus.almost_empty), 1);
      step(1, 6'h02, 0);
      check("s1_ae2",  32'(bus.almost_empty), 0);
      step(1, 6'h03, 0);
      check("s1_af3",  32'(bus.almost_full), 1);
      check("s1_full3", 32'(bus.full), 0);
      step(1, 6'h04, 0);
      check("s1_full4", 32'(bus.full), 1);
      check("s1_cnt4",  32'(bus.count), 4);
      for (int i = 0; i < 4; i++) begin
         step(0, 6'h00, 1);
         check($sformatf("s1_pop%0d_data", i), 32'(bus.data_out), 32'(i + 1));
         check($sformatf("s1_pop%0d_valid", i), 32'(bus.valid_out), 1);
      end
      check("s1_empty", 32'(bus.empty), 1);
      step(0, 6'h00, 0);
      check("s1_idle_valid", 32'(bus.valid_out), 0);
      check("s1_idle_hold",  32'(bus.data_out), 32'h04);

      // Overflow: push while full is dropped and flags error.
      step(1, 6'h0A, 0);
      step(1, 6'h0B, 0);
      step(1, 6'h0C, 0);
      step(1, 6'h0D, 0);
      step(1, 6'h3F, 0);
      check("s2_cnt",   32'(bus.count), 4);
      check("s2_error", 32'(bus.error), 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 6'h00, 1);
         check($sformatf("s2_pop%0d", i), 32'(bus.data_out), 32'(8'h0A + i));
      end
      check("s2_error_sticky", 32'(bus.error), 1);

      // Underflow: simultaneous push+pop on an empty FIFO.
      do_init(3'd3, 3'd1);
      check("s3_init_error", 32'(bus.error), 0);
      step(1, 6'h15, 1);
      check("s3_error", 32'(bus.error), 1);
      check("s3_cnt",   32'(bus.count), 1);
      check("s3_valid", 32'(bus.valid_out), 0);
      step(0, 6'h00, 1);
      check("s3_data",  32'(bus.data_out), 32'h15);
      check("s3_valid2", 32'(bus.valid_out), 1);

      // Init with new thresholds; push/pop during init are ignored.
      bus.init      = 1'b1;
      bus.umbral_af = 3'd3;
      bus.umbral_ae = 3'd0;
      step(1, 6'h33, 1);
      bus.init = 1'b0;
      check("s4_cnt0",  32'(bus.count), 0);
      check("s4_err0",  32'(bus.error), 0);
      check("s4_valid", 32'(bus.valid_out), 0);
      check("s4_ae0",   32'(bus.almost_empty), 1);
      step(1, 6'h11, 0);
      check("s4_ae1",   32'(bus.almost_empty), 0);
      step(1, 6'h12, 0);
      check("s4_af2",   32'(bus.almost_full), 0);
      step(1, 6'h13, 0);
      check("s4_af3",   32'(bus.almost_full), 1);
      step(1, 6'h14, 0);
      step(1, 6'h2A, 1);
      check("s4_fullpp_cnt",  32'(bus.count), 3);
      check("s4_fullpp_err",  32'(bus.error), 1);
      check("s4_fullpp_data", 32'(bus.data_out), 32'h11);
      step(0, 6'h00, 1);
      check("s4_next", 32'(bus.data_out), 32'h12);

      // Steady push/pop at count 2 across pointer wrap.
      do_init(3'd3, 3'd1);
      step(1, 6'h20, 0);
      step(1, 6'h21, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 6'(8'h22 + i), 1);
         check($sformatf("s5_data%0d", i), 32'(bus.data_out), 32'(8'h20 + i));
         check($sformatf("s5_cnt%0d", i),  32'(bus.count), 2);
      end

      // Asynchronous reset mid-burst at count 3.
      do_init(3'd3, 3'd1);
      step(1, 6'h05, 0);
      step(1, 6'h06, 0);
      step(1, 6'h07, 0);
      step(1, 6'h08, 1);
      check("s6_pre_cnt",  32'(bus.count), 3);
      check("s6_pre_data", 32'(bus.data_out), 32'h05);
      #2 reset = 1'b1;
      #1;
      check_reset_state("s6_async");
      #3 reset = 1'b0;
      step(1, 6'h09, 0);
      step(1, 6'h0E, 0);
      step(1, 6'h0F, 0);
      check("s6_af_reset", 32'(bus.almost_full), 1);
      step(0, 6'h00, 1);
      check("s6_fresh", 32'(bus.data_out), 32'h09);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tlp_fifo.md
TLP_FIFO -- requirements
Module: tlp_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, meaning the width of one stored TLP word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, meaning log2 of depth (DEPTH = 2**ADDR_WIDTH = 4).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port init, input, 1, a flush and threshold-load strobe from the flow-control FSM.
REQ-006 The block SHALL have port umbral_af, input, ADDR_WIDTH+1, the almost-full threshold, sampled during init.
REQ-007 The block SHALL have port umbral_ae, input, ADDR_WIDTH+1, the almost-empty threshold, sampled during init.
REQ-008 The block SHALL have port push, input, 1, a write request.
REQ-009 The block SHALL have port data_in, input, DATA_WIDTH, the write data.
REQ-010 The block SHALL have port pop, input, 1, a read request.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH, the registered read data.
REQ-012 The block SHALL have port valid_out, output, 1, asserted when data_out holds the word from last cycle's accepted pop.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1, the status flags consumed by the flow-control FSM.
REQ-014 The block SHALL have port error, output, 1, a sticky overflow/underflow flag.
REQ-015 The block SHALL have port count, output, ADDR_WIDTH+1, the current occupancy, 0..DEPTH.

Function
REQ-016 The block SHALL accept push when full==0, writing data_in at wr_ptr, incrementing wr_ptr modulo DEPTH.
REQ-017 The block SHALL accept pop when empty==0, registering mem[rd_ptr] into data_out, setting valid_out for exactly the next cycle, and incrementing rd_ptr modulo DEPTH.
REQ-018 The block SHALL implement pop latency of 1 cycle; there SHALL be no fall-through, so a push into an empty FIFO is not readable until the following cycle.
REQ-019 The block SHALL, when no pop is accepted, clear valid_out and hold data_out at its last value.
REQ-020 The block SHALL, when push and pop arrive in the same cycle with the FIFO neither empty nor full, accept both and leave count unchanged.
REQ-021 The block SHALL, when push and pop arrive in the same cycle while full, accept the pop and reject the push (overflow, error set), leaving count = DEPTH-1.
REQ-022 The block SHALL, when push and pop arrive in the same cycle while empty, accept the push and reject the pop (underflow, error set), leaving count = 1.
REQ-023 The block SHALL drop a rejected push without changing memory or pointers.
REQ-024 The block SHALL leave pointers and data_out unchanged on a rejected pop and keep valid_out low.
REQ-025 The block SHALL, once error is set, hold it until reset or init.
REQ-026 The block SHALL drive full = (count==DEPTH) and empty = (count==0) combinationally from count.
REQ-027 The block SHALL drive almost_full = (count >= af_reg) and almost_empty = (count <= ae_reg), where af_reg and ae_reg are the latched thresholds.
REQ-028 The block SHALL, on a cycle with init high, latch umbral_af into af_reg and umbral_ae into ae_reg, reset pointers and count to 0, and clear error and valid_out.
REQ-029 The block SHALL ignore push and pop during any cycle with init high.
REQ-030 The block SHALL not check threshold legality; out-of-range values simply yield constant flags.

Reset
REQ-031 The block SHALL, while reset is high, asynchronously set pointers=0, count=0, data_out=0, valid_out=0, error=0, af_reg=DEPTH-1 and ae_reg=1.
REQ-032 The block SHALL drive flags out of reset as empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-033 The block SHALL, on reset asserted mid-operation, discard all stored words; memory contents need not be cleared.

Structure
REQ-034 The DATA_WIDTH/ADDR_WIDTH defaults and the reset threshold values SHALL live in the shared TLP defines file used by the FSM and the muxes.
REQ-035 The storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_WIDTH register array with a synchronous write port and an address-indexed read port; pointers, count, flags and error SHALL stay in tlp_fifo.

Verification
REQ-036 Scenario: reset, then push 0x01,0x02,0x03,0x04 -> full=1 after 4th push, count=4; then pop x4 -> data_out 0x01..0x04 each one cycle after its pop, with valid_out high those cycles, and finally empty=1.
REQ-037 Scenario: with the FIFO full, push 0x3F -> count stays 4 and error=1; later pops return the original 4 words, with 0x3F absent.
REQ-038 Scenario: on an empty FIFO, push 0x15 and pop simultaneously -> error=1, count=1; next-cycle pop returns 0x15.
REQ-039 Scenario: init with umbral_af=3 and umbral_ae=0 -> almost_full rises on the 3rd push, and almost_empty is high only at count=0; error is cleared by the init.
REQ-040 Scenario: 10 push/pop pairs at count=2 -> count stays 2 and data is in order across pointer wrap-around.
REQ-041 Scenario: reset asserted asynchronously mid-burst at count=3 -> outputs return to their reset values immediately (before the next clk edge).
